// File: rtl/multicycle_ctrl_if.sv
// Memory-side handshake bundle for the multicycle controller.
// master = controller, slave = instruction/data memory.
interface multicycle_ctrl_if;
   logic        imem_req;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        dmem_req;
   logic        dmem_we;
   logic        dmem_ack;

   modport master (
      output imem_req, dmem_req, dmem_we,
      input  imem_ack, imem_rdata, dmem_ack
   );

   modport slave (
      input  imem_req, dmem_req, dmem_we,
      output imem_ack, imem_rdata, dmem_ack
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 subset control FSM: fetch/decode/exec/mem/wb sequencing,
// bus wait timeout and sticky trap on illegal opcode or bus error.
module multicycle_ctrl #(
   parameter int TIMEOUT = 15
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     br_taken,
   multicycle_ctrl_if.master        bus,
   output logic [31:0]              ir,
   output logic [2:0]               imm_sel,
   output logic                     alu_src_imm,
   output logic                     rf_we,
   output logic [1:0]               wb_sel,
   output logic                     pc_we,
   output logic [1:0]               pc_sel,
   output logic                     retire,
   output logic [2:0]               state,
   output logic                     illegal,
   output logic                     bus_err
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] FETCH  = 3'd1;
   localparam logic [2:0] DECODE = 3'd2;
   localparam logic [2:0] EXEC   = 3'd3;
   localparam logic [2:0] MEM    = 3'd4;
   localparam logic [2:0] WB     = 3'd5;
   localparam logic [2:0] TRAP   = 3'd6;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   logic [2:0]  state_reg;
   logic [31:0] ir_reg;
   logic [7:0]  cnt_reg;
   logic        illegal_reg;
   logic        bus_err_reg;

   logic [6:0] opc;
   logic [2:0] funct3;
   logic       is_alu_r, is_alu_i, is_br, is_jal, is_ld, is_st, is_legal;

   assign opc      = ir_reg[6:0];
   assign funct3   = ir_reg[14:12];
   assign is_alu_r = (opc == 7'b0110011);
   assign is_alu_i = (opc == 7'b0010011);
   assign is_br    = (opc == 7'b1100011);
   assign is_jal   = (opc == 7'b1101111);
   assign is_ld    = (opc == 7'b0000011);
   assign is_st    = (opc == 7'b0100011);
   // Only word and byte widths are supported for memory ops.
   assign is_legal = is_alu_r | is_alu_i | is_br | is_jal |
                     ((is_ld | is_st) & ((funct3 == 3'b000) | (funct3 == 3'b010)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         ir_reg      <= 32'h0000_0013;
         cnt_reg     <= 8'd0;
         illegal_reg <= 1'b0;
         bus_err_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  state_reg <= FETCH;
                  cnt_reg   <= 8'd0;
               end
            end
            FETCH: begin
               if (bus.imem_ack) begin
                  ir_reg    <= bus.imem_rdata;
                  state_reg <= DECODE;
               end else if (cnt_reg == CNT_LAST) begin
                  bus_err_reg <= 1'b1;
                  state_reg   <= TRAP;
               end else begin
                  cnt_reg <= cnt_reg + 8'd1;
               end
            end
            DECODE: begin
               if (is_legal) begin
                  state_reg <= EXEC;
               end else begin
                  illegal_reg <= 1'b1;
                  state_reg   <= TRAP;
               end
            end
            EXEC: begin
               cnt_reg <= 8'd0;
               if (is_ld | is_st)
                  state_reg <= MEM;
               else if (is_alu_r | is_alu_i)
                  state_reg <= WB;
               else
                  state_reg <= FETCH;
            end
            MEM: begin
               if (bus.dmem_ack) begin
                  cnt_reg   <= 8'd0;
                  state_reg <= is_st ? FETCH : WB;
               end else if (cnt_reg == CNT_LAST) begin
                  bus_err_reg <= 1'b1;
                  state_reg   <= TRAP;
               end else begin
                  cnt_reg <= cnt_reg + 8'd1;
               end
            end
            WB: begin
               cnt_reg   <= 8'd0;
               state_reg <= FETCH;
            end
            TRAP: state_reg <= TRAP;
            default: state_reg <= IDLE;
         endcase
      end
   end

   logic rf_we_raw;
   logic imem_req_c, dmem_req_c, dmem_we_c;

   always_comb begin
      rf_we_raw   = 1'b0;
      wb_sel      = 2'd0;
      pc_we       = 1'b0;
      pc_sel      = 2'd0;
      retire      = 1'b0;
      alu_src_imm = 1'b0;
      imem_req_c  = 1'b0;
      dmem_req_c  = 1'b0;
      dmem_we_c   = 1'b0;
      case (state_reg)
         FETCH: imem_req_c = 1'b1;
         EXEC: begin
            alu_src_imm = is_alu_i | is_ld | is_st;
            if (is_br) begin
               pc_we  = 1'b1;
               pc_sel = br_taken ? 2'd1 : 2'd0;
               retire = 1'b1;
            end
            if (is_jal) begin
               rf_we_raw = 1'b1;
               wb_sel    = 2'd2;
               pc_we     = 1'b1;
               pc_sel    = 2'd2;
               retire    = 1'b1;
            end
         end
         MEM: begin
            alu_src_imm = 1'b1;
            dmem_req_c  = 1'b1;
            dmem_we_c   = is_st;
            // Stores complete on the ack itself; loads still need WB.
            if (bus.dmem_ack && is_st) begin
               pc_we  = 1'b1;
               retire = 1'b1;
            end
         end
         WB: begin
            alu_src_imm = is_alu_i;
            rf_we_raw   = 1'b1;
            wb_sel      = is_ld ? 2'd1 : 2'd0;
            pc_we       = 1'b1;
            retire      = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      imm_sel = 3'd0;
      if (is_alu_i | is_ld) imm_sel = 3'd1;
      if (is_st)            imm_sel = 3'd2;
      if (is_br)            imm_sel = 3'd3;
      if (is_jal)           imm_sel = 3'd4;
   end

   assign rf_we        = rf_we_raw & (ir_reg[11:7] != 5'd0);
   assign bus.imem_req = imem_req_c;
   assign bus.dmem_req = dmem_req_c;
   assign bus.dmem_we  = dmem_we_c;
   assign ir           = ir_reg;
   assign state        = state_reg;
   assign illegal      = illegal_reg;
   assign bus_err      = bus_err_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: memory responders feed a program,
// a monitor compares every retire against hand-computed expectations.
module tb_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        br_taken;
   logic [31:0] ir;
   logic [2:0]  imm_sel;
   logic        alu_src_imm;
   logic        rf_we;
   logic [1:0]  wb_sel;
   logic        pc_we;
   logic [1:0]  pc_sel;
   logic        retire;
   logic [2:0]  state;
   logic        illegal;
   logic        bus_err;

   multicycle_ctrl_if bus_if();

   multicycle_ctrl #(.TIMEOUT(15)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .br_taken    (br_taken),
      .bus         (bus_if),
      .ir          (ir),
      .imm_sel     (imm_sel),
      .alu_src_imm (alu_src_imm),
      .rf_we       (rf_we),
      .wb_sel      (wb_sel),
      .pc_we       (pc_we),
      .pc_sel      (pc_sel),
      .retire      (retire),
      .state       (state),
      .illegal     (illegal),
      .bus_err     (bus_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      int          ilat;
      int          dlat;
      logic        br;
   } prog_t;

   typedef struct {
      int          id;
      logic        rf;
      logic [1:0]  wb;
      logic [1:0]  pcs;
      logic [2:0]  imm;
      logic        asrc;
      int          lat;
      int          dcyc;
      logic        dwe;
   } exp_t;

   prog_t prog_q[$];
   exp_t  exp_q[$];

   int errors = 0;
   int checks = 0;
   int retire_cnt = 0;
   int last_irun = 0;
   int dlat_cur = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Sample point: mid-low phase, after responders have updated acks.
   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   task automatic push_instr(input logic [31:0] instr, input int ilat, input int dlat, input logic br);
      prog_t p;
      p.instr = instr; p.ilat = ilat; p.dlat = dlat; p.br = br;
      prog_q.push_back(p);
   endtask

   task automatic push_exp(input int id, input logic rf, input logic [1:0] wb, input logic [1:0] pcs,
                           input logic [2:0] imm, input logic asrc, input int lat, input int dcyc,
                           input logic dwe);
      exp_t e;
      e.id = id; e.rf = rf; e.wb = wb; e.pcs = pcs; e.imm = imm; e.asrc = asrc;
      e.lat = lat; e.dcyc = dcyc; e.dwe = dwe;
      exp_q.push_back(e);
   endtask

   task automatic wait_state(input logic [2:0] s, input int budget);
      int n;
      n = 0;
      while (state !== s && n < budget) begin
         tick();
         n++;
      end
      check("wait_state", {29'd0, state}, {29'd0, s});
   endtask

   // Instruction memory: acks after ilat waiting cycles; empty program never acks.
   initial begin
      int icnt;
      icnt = 0;
      bus_if.imem_ack   = 1'b0;
      bus_if.imem_rdata = 32'd0;
      br_taken          = 1'b0;
      forever begin
         @(negedge clk);
         if (bus_if.imem_req === 1'b1) begin
            if (prog_q.size() > 0 && icnt == prog_q[0].ilat) begin
               bus_if.imem_ack   = 1'b1;
               bus_if.imem_rdata = prog_q[0].instr;
               br_taken          = prog_q[0].br;
               dlat_cur          = prog_q[0].dlat;
               void'(prog_q.pop_front());
            end else begin
               bus_if.imem_ack = 1'b0;
            end
            icnt++;
         end else begin
            icnt = 0;
            bus_if.imem_ack = 1'b0;
         end
      end
   end

   initial begin
      int dcnt;
      dcnt = 0;
      bus_if.dmem_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (bus_if.dmem_req === 1'b1) begin
            bus_if.dmem_ack = (dcnt == dlat_cur);
            dcnt++;
         end else begin
            dcnt = 0;
            bus_if.dmem_ack = 1'b0;
         end
      end
   end

   // Monitor: per-instruction accumulation from FETCH entry, compare at retire.
   initial begin
      logic [2:0] prev_state;
      int   cyc, dcyc, irun;
      logic dwe, asrc;
      exp_t e;
      prev_state = 3'd0;
      cyc = 0; dcyc = 0; irun = 0; dwe = 1'b0; asrc = 1'b0;
      forever begin
         tick();
         if (state == 3'd1 && prev_state != 3'd1) begin
            cyc = 1; dcyc = 0; dwe = 1'b0; asrc = 1'b0;
         end else begin
            cyc++;
         end
         if (bus_if.imem_req === 1'b1) irun++;
         else if (irun > 0) begin
            last_irun = irun;
            irun = 0;
         end
         if (bus_if.dmem_req === 1'b1) begin
            dcyc++;
            dwe = dwe | bus_if.dmem_we;
         end
         if (state == 3'd3) asrc = alu_src_imm;
         if (retire === 1'b1) begin
            retire_cnt++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_retire: got retire=1 expected none, ir=0x%08h", ir);
            end else begin
               e = exp_q.pop_front();
               $display("retire #%0d ir=0x%08h rf_we=%0d wb_sel=%0d pc_sel=%0d imm_sel=%0d lat=%0d",
                        e.id, ir, rf_we, wb_sel, pc_sel, imm_sel, cyc);
               check("rf_we",       {31'd0, rf_we},       {31'd0, e.rf});
               check("wb_sel",      {30'd0, wb_sel},      {30'd0, e.wb});
               check("pc_sel",      {30'd0, pc_sel},      {30'd0, e.pcs});
               check("pc_we",       {31'd0, pc_we},       32'd1);
               check("imm_sel",     {29'd0, imm_sel},     {29'd0, e.imm});
               check("alu_src_imm", {31'd0, asrc},        {31'd0, e.asrc});
               check("latency",     cyc,                  e.lat);
               check("dmem_cycles", dcyc,                 e.dcyc);
               check("dmem_we",     {31'd0, dwe},         {31'd0, e.dwe});
            end
         end
         prev_state = state;
      end
   end

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      prog_q.delete();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      tick();
      tick();
      check("rst_state",    {29'd0, state},           32'd0);
      check("rst_ir",       ir,                        32'h0000_0013);
      check("rst_illegal",  {31'd0, illegal},          32'd0);
      check("rst_bus_err",  {31'd0, bus_err},          32'd0);
      check("rst_imem_req", {31'd0, bus_if.imem_req},  32'd0);
      check("rst_retire",   {31'd0, retire},           32'd0);
      check("rst_pc_we",    {31'd0, pc_we},            32'd0);
      rst_n = 1'b1;
      repeat (3) tick();
      check("idle_wait", {29'd0, state}, 32'd0);

      // Program A: mixed instructions, then fetch timeout.
      //          instr         ilat dlat br     id rf wb pcs imm asrc lat dcyc dwe
      push_instr(32'h0050_0093, 0, 0, 1'b0); push_exp(1, 1, 0, 0, 1, 1, 4, 0, 0);
      push_instr(32'h0000_A103, 0, 3, 1'b0); push_exp(2, 1, 1, 0, 1, 1, 8, 4, 0);
      push_instr(32'h0020_A023, 1, 0, 1'b0); push_exp(3, 0, 0, 0, 2, 1, 5, 1, 1);
      push_instr(32'h0000_0063, 0, 0, 1'b1); push_exp(4, 0, 0, 1, 3, 0, 3, 0, 0);
      push_instr(32'h0000_0063, 2, 0, 1'b0); push_exp(5, 0, 0, 0, 3, 0, 5, 0, 0);
      push_instr(32'h0080_006F, 0, 0, 1'b0); push_exp(6, 0, 2, 2, 4, 0, 3, 0, 0);
      push_instr(32'h0080_00EF, 0, 0, 1'b0); push_exp(7, 1, 2, 2, 4, 0, 3, 0, 0);
      push_instr(32'h0020_81B3, 0, 0, 1'b0); push_exp(8, 1, 0, 0, 0, 0, 4, 0, 0);
      push_instr(32'h0000_0013, 0, 0, 1'b0); push_exp(9, 0, 0, 0, 1, 1, 4, 0, 0);
      pulse_start();
      wait_state(3'd6, 400);
      tick();
      check("timeout_bus_err",  {31'd0, bus_err}, 32'd1);
      check("timeout_illegal",  {31'd0, illegal}, 32'd0);
      check("timeout_req_len",  last_irun,        15);
      check("progA_retires",    retire_cnt,       9);
      check("progA_drained",    exp_q.size(),     0);
      start = 1'b1;
      repeat (4) tick();
      start = 1'b0;
      check("trap_hold",        {29'd0, state},          32'd6);
      check("trap_imem_req",    {31'd0, bus_if.imem_req}, 32'd0);
      check("trap_bus_err",     {31'd0, bus_err},        32'd1);

      // Program B: ack on the last allowed cycle, then an illegal word.
      do_reset();
      check("reset_clears_err", {31'd0, bus_err}, 32'd0);
      push_instr(32'h0050_0093, 14, 0, 1'b0); push_exp(10, 1, 0, 0, 1, 1, 18, 0, 0);
      push_instr(32'hFFFF_FFFF, 0, 0, 1'b0);
      pulse_start();
      wait_state(3'd6, 200);
      tick();
      check("late_ack_no_err",  {31'd0, bus_err}, 32'd0);
      check("ffff_illegal",     {31'd0, illegal}, 32'd1);
      check("progB_retires",    retire_cnt,       10);
      check("progB_drained",    exp_q.size(),     0);

      // Program C: lh is not a supported width.
      do_reset();
      push_instr(32'h0000_1083, 0, 0, 1'b0);
      pulse_start();
      wait_state(3'd6, 50);
      tick();
      check("lh_illegal",       {31'd0, illegal}, 32'd1);
      check("lh_no_retire",     retire_cnt,       10);

      // Program D: reset asserted while a load waits in MEM.
      do_reset();
      push_instr(32'h0000_A103, 0, 100, 1'b0);
      pulse_start();
      wait_state(3'd4, 50);
      tick();
      tick();
      check("mem_req_before_rst", {31'd0, bus_if.dmem_req}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("midmem_state",    {29'd0, state},            32'd0);
      check("midmem_dmem_req", {31'd0, bus_if.dmem_req},  32'd0);
      check("midmem_ir",       ir,                         32'h0000_0013);
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
      check("post_rst_idle",   {29'd0, state},            32'd0);
      check("final_retires",   retire_cnt,                 10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 15, max cycles a bus request may wait for ack (range 2..255).
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  begin execution; sampled only in IDLE.
REQ-005 imem_req out 1 / imem_ack in 1 / imem_rdata in 32  instruction fetch handshake and data.
REQ-006 dmem_req out 1 / dmem_we out 1 / dmem_ack in 1  data memory handshake; dmem_we=1 for stores.
REQ-007 br_taken  in  1  branch compare result from ALU, valid in EXEC.
REQ-008 ir  out  32  instruction register, drives immediate generator and register-file addresses.
REQ-009 imm_sel  out  3  0 none, 1 I, 2 S, 3 B, 4 J; decoded from ir[6:0].
REQ-010 alu_src_imm  out  1  ALU operand B from immediate.
REQ-011 rf_we out 1; wb_sel out 2 (0 ALU, 1 MEM, 2 PC+4)  register write-back control.
REQ-012 pc_we out 1; pc_sel out 2 (0 PC+4, 1 branch target, 2 JAL target)  PC update control.
REQ-013 retire out 1 (one-cycle pulse per completed instruction); state out 3; illegal out 1; bus_err out 1.

Function
REQ-014 States SHALL be IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6; state output SHALL equal the current state register.
REQ-015 IDLE: start=1 -> FETCH; start in any other state SHALL be ignored.
REQ-016 FETCH: imem_req=1 held until imem_ack; on ack ir<=imem_rdata, -> DECODE.
REQ-017 DECODE: legal = opcode 0110011, 0010011, 1100011, 1101111, or opcode 0000011/0100011 with funct3 000 or 010; legal -> EXEC, otherwise illegal<=1, -> TRAP.
REQ-018 EXEC, R/I-ALU: alu_src_imm=1 for 0010011 only, -> WB.
REQ-019 EXEC, load/store: alu_src_imm=1, -> MEM.
REQ-020 EXEC, branch: pc_we=1, pc_sel=br_taken?1:0, retire=1, -> FETCH.
REQ-021 EXEC, JAL: rf_we=1, wb_sel=2, pc_we=1, pc_sel=2, retire=1, -> FETCH.
REQ-022 MEM: dmem_req=1, dmem_we=1 for store, held until dmem_ack; store ack -> pc_we=1, pc_sel=0, retire=1, -> FETCH; load ack -> WB.
REQ-023 WB: rf_we=1, wb_sel=1 for load else 0, pc_we=1, pc_sel=0, retire=1, -> FETCH.
REQ-024 rf_we SHALL be forced 0 when ir[11:7]==0.
REQ-025 Control outputs other than ir/illegal/bus_err SHALL be combinational functions of state, ir, br_taken and the acks; each enable is high for exactly one cycle per instruction except the req signals.
REQ-026 Wait counter: cleared on entry to FETCH/MEM, +1 per cycle req=1 without ack; ack accepted in any cycle up to and including count TIMEOUT-1; no ack at count TIMEOUT-1 -> bus_err<=1, -> TRAP; req therefore never exceeds TIMEOUT consecutive cycles.
REQ-027 Acks received while the corresponding req=0 SHALL be ignored.
REQ-028 TRAP: all enables and reqs 0; state held until reset; illegal/bus_err sticky.
REQ-029 Latency with same-cycle ack: ALU 4 cycles, load 5, store 4, branch 3, JAL 3 (FETCH entry to retire inclusive).

Reset
REQ-030 rst_n=0 SHALL immediately force state=IDLE, ir=32'h00000013, counter=0, illegal=0, bus_err=0, all enables/reqs/retire=0, including mid-handshake; after release block waits for start.

Verification
REQ-031 start, ir=0x00500093 (addi x1,x0,5), immediate ack -> states 1,2,3,5; cycle 4 rf_we=1, wb_sel=0, pc_we=1, retire=1; imm_sel=1, alu_src_imm=1.
REQ-032 lw 0x0000A103, dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0, then WB rf_we=1 wb_sel=1; sw 0x0020A023 -> dmem_we=1, no rf_we, retire on ack, imm_sel=2.
REQ-033 beq with br_taken=1 then 0 -> pc_sel=1 then 0, imm_sel=3, 3-cycle retire; JAL x0 -> rf_we=0, pc_sel=2, imm_sel=4.
REQ-034 TIMEOUT=15, imem_ack never -> imem_req high 15 cycles, bus_err=1, state=6 held; ack on 15th cycle -> accepted, no error.
REQ-035 ir=0xFFFFFFFF or lh 0x00001083 -> illegal=1, state=6, no retire; rst_n low mid-MEM -> immediate IDLE, dmem_req=0, ir=0x00000013.
